// File: rtl/misr_pkg.sv
// Shared definitions for the MISR response compactor: FSM state encoding
// and the per-width feedback tap table.
package misr_pkg;

    // Widest supported signature (N = 150 -> 151 bits).
    localparam int MISR_MAX_W = 151;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2
    } misr_state_e;

    // Tap mask for signature MSB index n; bit t set means sig[t] feeds back.
    // An all-zero mask marks an unsupported width.
    function automatic logic [MISR_MAX_W-1:0] misr_taps(input int n);
        logic [MISR_MAX_W-1:0] m;
        m = '0;
        case (n)
            3:   begin m[3]   = 1'b1; m[2]   = 1'b1; m[0] = 1'b1; end
            4:   begin m[4]   = 1'b1; m[3]   = 1'b1; m[0] = 1'b1; end
            5:   begin m[5]   = 1'b1; m[3]   = 1'b1; m[0] = 1'b1; end
            9:   begin m[9]   = 1'b1; m[5]   = 1'b1; m[0] = 1'b1; end
            10:  begin m[10]  = 1'b1; m[7]   = 1'b1; m[0] = 1'b1; end
            16:  begin m[16]  = 1'b1; m[15]  = 1'b1; m[13] = 1'b1; m[4]  = 1'b1; m[0] = 1'b1; end
            50:  begin m[50]  = 1'b1; m[49]  = 1'b1; m[24] = 1'b1; m[23] = 1'b1; m[0] = 1'b1; end
            100: begin m[100] = 1'b1; m[63]  = 1'b1; m[0] = 1'b1; end
            114: begin m[114] = 1'b1; m[113] = 1'b1; m[33] = 1'b1; m[32] = 1'b1; m[0] = 1'b1; end
            120: begin m[120] = 1'b1; m[113] = 1'b1; m[9]  = 1'b1; m[2]  = 1'b1; m[0] = 1'b1; end
            150: begin m[150] = 1'b1; m[97]  = 1'b1; m[0] = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic bit misr_supported(input int n);
        return misr_taps(n) != '0;
    endfunction

endpackage

// File: rtl/misr_core.sv
// MISR signature register datapath: load seed, compact one word, or hold.
// No control logic lives here; the top level decides when to load/step.
module misr_core #(
    parameter int         N    = 16,
    parameter logic [N:0] SEED = 1,
    parameter logic [N:0] TAPS = '0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic [N:0] data,
    output logic [N:0] sig
);

    logic fb;
    assign fb = ^(sig & TAPS);

    // Signature register: seed on load, shift-with-feedback XOR data on step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sig <= SEED;
        else if (load)
            sig <= SEED;
        else if (step)
            sig <= {fb ^ data[N], sig[N:1] ^ data[N-1:0]};
    end

endmodule

// File: rtl/misr_compactor.sv
// MISR response compactor with start/done framing and golden compare.
// Optional feature: define MISR_XMASK_EN to add a data_mask port that
// forces masked (unknown) response bits to zero before compaction.
module misr_compactor
    import misr_pkg::*;
#(
    parameter int         N     = 16,
    parameter logic [N:0] SEED  = 1,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] length,
    input  logic [N:0]       golden,
    input  logic             data_valid,
    input  logic [N:0]       data_in,
`ifdef MISR_XMASK_EN
    input  logic [N:0]       data_mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N:0]       signature
);

    localparam logic [MISR_MAX_W-1:0] TAPS_ALL = misr_taps(N);
    localparam logic [N:0]            TAPS     = TAPS_ALL[N:0];

    if (!misr_supported(N)) begin : g_bad_width
        $error("misr_compactor: unsupported N=%0d", N);
    end

    misr_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             load, step;
    logic [N:0]       word;

`ifdef MISR_XMASK_EN
    assign word = data_in & ~data_mask;
`else
    assign word = data_in;
`endif

    // Next-state and datapath strobes; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                load    = 1'b1;
                state_d = (length == '0) ? CMP : RUN;
            end
            RUN: if (data_valid) begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1))
                    state_d = CMP;
            end
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, word counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_q == CMP);
            if (load)
                cnt_q <= length;
            else if (step)
                cnt_q <= cnt_q - CNT_W'(1);
            if (load)
                pass <= 1'b0;
            else if (state_q == CMP)
                pass <= (signature == golden);
        end
    end

    misr_core #(
        .N    (N),
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .data  (word),
        .sig   (signature)
    );

endmodule

// File: tb/tb_misr_compactor.sv
// Directed bench for misr_compactor at N=3, SEED=1 (taps {3,2,0}).
module tb_misr_compactor;

    localparam int N     = 3;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] length;
    logic [N:0]       golden;
    logic             data_valid;
    logic [N:0]       data_in;
`ifdef MISR_XMASK_EN
    logic [N:0]       data_mask = '0;
`endif
    logic             busy, done, pass;
    logic [N:0]       signature;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    misr_compactor #(.N(N), .SEED(4'h1), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .length     (length),
        .golden     (golden),
        .data_valid (data_valid),
        .data_in    (data_in),
`ifdef MISR_XMASK_EN
        .data_mask  (data_mask),
`endif
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int len, input logic [N:0] gold);
        start  = 1'b1;
        length = CNT_W'(len);
        golden = gold;
        cyc();
        start  = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_sig", 32'(signature), 32'h1);
    endtask

    task automatic word(input logic v, input logic [N:0] d, input logic [N:0] exp_sig, input string tag);
        data_valid = v;
        data_in    = d;
        cyc();
        data_valid = 1'b0;
        chk(tag, 32'(signature), 32'(exp_sig));
    endtask

    task automatic finish_run(input logic exp_pass, input logic [N:0] exp_sig, input string tag);
        chk({tag, "_busy_cmp"}, 32'(busy), 32'd1);
        chk({tag, "_nodone_cmp"}, 32'(done), 32'd0);
        cyc();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_sig"}, 32'(signature), 32'(exp_sig));
        cyc();
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        chk({tag, "_pass_hold"}, 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; length = '0; golden = 4'h6;
        data_valid = 1'b0; data_in = '0;
        #12;
        chk("rst_sig", 32'(signature), 32'h1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        reset = 1'b0;
        cyc();

        // Valid in IDLE must not disturb the signature.
        word(1'b1, 4'hF, 4'h1, "idle_hold");

        // Three zero words, golden matches.
        kick(3, 4'h6);
        word(1'b1, 4'h0, 4'h8, "s1_w0");
        word(1'b1, 4'h0, 4'hC, "s1_w1");
        word(1'b1, 4'h0, 4'h6, "s1_w2");
        finish_run(1'b1, 4'h6, "s1");

        // Same stream, golden mismatch.
        kick(3, 4'h5);
        chk("s2_pass_clr", 32'(pass), 32'd0);
        word(1'b1, 4'h0, 4'h8, "s2_w0");
        word(1'b1, 4'h0, 4'hC, "s2_w1");
        word(1'b1, 4'h0, 4'h6, "s2_w2");
        finish_run(1'b0, 4'h6, "s2");

        // Single word 4'hF.
        kick(1, 4'h7);
        word(1'b1, 4'hF, 4'h7, "s3_w0");
        finish_run(1'b1, 4'h7, "s3");

        // Valid gaps 1,0,0,1,1.
        kick(3, 4'h6);
        word(1'b1, 4'h0, 4'h8, "s4_c0");
        word(1'b0, 4'hF, 4'h8, "s4_gap0");
        word(1'b0, 4'hA, 4'h8, "s4_gap1");
        word(1'b1, 4'h0, 4'hC, "s4_c3");
        word(1'b1, 4'h0, 4'h6, "s4_c4");
        finish_run(1'b1, 4'h6, "s4");

        // length = 0: compare the seed directly.
        kick(0, 4'h6);
        finish_run(1'b0, 4'h1, "s5a");
        kick(0, 4'h1);
        finish_run(1'b1, 4'h1, "s5b");

        // Async reset after the 2nd word aborts the run.
        kick(3, 4'h6);
        word(1'b1, 4'h0, 4'h8, "s6_w0");
        word(1'b1, 4'h0, 4'hC, "s6_w1");
        #2 reset = 1'b1;
        #1;
        chk("s6_rst_sig", 32'(signature), 32'h1);
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_done", 32'(done), 32'd0);
        chk("s6_rst_pass", 32'(pass), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            word(1'b1, 4'h0, 4'h1, "s6_post_sig");
            chk("s6_post_done", 32'(done), 32'd0);
            chk("s6_post_busy", 32'(busy), 32'd0);
        end

        // Start during RUN is ignored: no reload, length unchanged.
        kick(3, 4'h6);
        word(1'b1, 4'h0, 4'h8, "s7_w0");
        start = 1'b1; length = CNT_W'(1);
        word(1'b1, 4'h0, 4'hC, "s7_w1_start");
        start = 1'b0;
        chk("s7_still_busy", 32'(busy), 32'd1);
        word(1'b1, 4'h0, 4'h6, "s7_w2");
        finish_run(1'b1, 4'h6, "s7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim did not finish, want finish before 50000");
        $fatal(1);
    end

endmodule
